// File: rtl/spi_register_controller_pkg.sv
// spi_register_controller_pkg: shared FSM encodings and default field widths for the SPI register controller
package spi_register_controller_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/spi_register_controller.sv
// spi_register_controller: decodes completed SPI frames into handshaked register bus accesses and publishes the result word
// Ports: system_clk/reset (async, active-high); spi_value_mosi/spi_value_valid/spi_cs_stop from the SPI slave;
// spi_value_miso response word to the slave; bus_req/bus_we/bus_addr/bus_wdata/bus_ack/bus_rdata register bus;
// busy (in ACCESS), overrun (command dropped while busy), timeout (access abandoned).
module spi_register_controller
  import spi_register_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  system_clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      spi_value_mosi,
  input  logic                  spi_value_valid,
  input  logic                  spi_cs_stop,
  output logic [WIDTH-1:0]      spi_value_miso,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);
  localparam int WE_BIT = WIDTH - 1;
  localparam int ADDR_LSB = DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  logic [0:0] state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic timeout_q, timeout_d;
  logic accept, in_access;
  assign accept = spi_cs_stop && spi_value_valid;
  assign in_access = state_q == ACCESS;
  // Saturating increment; the access expires on the cycle this reaches the limit.
  assign cnt_inc = cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    resp_d = resp_q;
    cnt_d = cnt_q;
    timeout_d = 1'b0;
    if (!in_access) begin
      if (accept) begin
        state_d = ACCESS;
        we_d = spi_value_mosi[WE_BIT];
        addr_d = spi_value_mosi[WE_BIT-1:ADDR_LSB];
        wdata_d = spi_value_mosi[DATA_WIDTH-1:0];
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_inc;
      // Ack takes priority over an expiry landing in the same cycle.
      if (bus_ack) begin
        state_d = IDLE;
        resp_d = {1'b0, addr_q, we_q ? wdata_q : bus_rdata};
      end else if (cnt_inc == CNT_MAX) begin
        state_d = IDLE;
        resp_d = {1'b1, addr_q, {DATA_WIDTH{1'b0}}};
        timeout_d = 1'b1;
      end
    end
  end
  always_ff @(posedge system_clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  assign bus_req = in_access;
  assign busy = in_access;
  assign bus_we = we_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign timeout = timeout_q;
  assign overrun = accept && in_access;
  // While an access is outstanding the slave shifts out a "not ready" marker instead of a stale result.
  assign spi_value_miso = in_access ? {1'b1, addr_q, {DATA_WIDTH{1'b1}}} : resp_q;
endmodule

// File: tb/tb_spi_register_controller.sv
// tb_spi_register_controller: table-driven, randomized and hand-sequenced checks of spi_register_controller
module tb_spi_register_controller;
  localparam int T = 16;
  logic system_clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] spi_value_mosi = '0;
  logic spi_value_valid = 1'b0;
  logic spi_cs_stop = 1'b0;
  logic [31:0] spi_value_miso;
  logic bus_req, bus_we, bus_ack = 1'b0, busy, overrun, timeout;
  logic [6:0] bus_addr;
  logic [23:0] bus_wdata, bus_rdata = '0;
  int vectors = 0;
  int miscompares = 0;
  spi_register_controller #(.TIMEOUT_CYCLES(T)) dut (
    .system_clk(system_clk), .reset(reset),
    .spi_value_mosi(spi_value_mosi), .spi_value_valid(spi_value_valid), .spi_cs_stop(spi_cs_stop),
    .spi_value_miso(spi_value_miso),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );
  always #5 system_clk = ~system_clk;
  typedef struct {
    logic we;
    logic [6:0] addr;
    logic [23:0] wd;
    logic bsy;
    logic [31:0] mbusy;
    int reqs;
    int touts;
    int ovr;
    logic [31:0] miso;
    int late;
  } res_t;
  typedef struct {
    logic [31:0] cmd;
    int delay;
    logic [23:0] rdata;
    int coll_at;
    logic [31:0] coll;
    res_t exp;
  } vec_t;
  task automatic tick;
    @(posedge system_clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Behavioural expectation of one command: acked in request cycle delay+1 if that is within the
  // timeout window, otherwise abandoned after T request cycles.
  function automatic res_t model(input logic [31:0] cmd, input int delay, input logic [23:0] rdata, input int coll_at);
    res_t r;
    bit acked;
    acked = delay < T;
    r.we = cmd[31];
    r.addr = cmd[30:24];
    r.wd = cmd[23:0];
    r.bsy = 1'b1;
    r.mbusy = {1'b1, cmd[30:24], 24'hFFFFFF};
    r.reqs = acked ? delay + 1 : T;
    r.touts = acked ? 0 : 1;
    r.ovr = (coll_at >= 0 && coll_at < r.reqs) ? 1 : 0;
    r.miso = acked ? {1'b0, cmd[30:24], cmd[31] ? cmd[23:0] : rdata} : {1'b1, cmd[30:24], 24'h0};
    r.late = 0;
    return r;
  endfunction
  task automatic run_cmd(input logic [31:0] cmd, input int delay, input logic [23:0] rdata,
                         input int coll_at, input logic [31:0] coll, output res_t r);
    spi_value_mosi = cmd;
    spi_value_valid = 1'b1;
    spi_cs_stop = 1'b1;
    tick;
    spi_value_valid = 1'b0;
    spi_cs_stop = 1'b0;
    r.we = bus_we;
    r.addr = bus_addr;
    r.wd = bus_wdata;
    r.bsy = busy;
    r.mbusy = spi_value_miso;
    r.reqs = 0;
    r.touts = 0;
    r.ovr = 0;
    while (bus_req && r.reqs < 64) begin
      bus_ack = (r.reqs == delay);
      bus_rdata = bus_ack ? rdata : ~rdata;
      if (r.reqs == coll_at) begin
        spi_value_mosi = coll;
        spi_value_valid = 1'b1;
        spi_cs_stop = 1'b1;
      end
      #1;
      r.ovr += int'(overrun);
      tick;
      r.reqs++;
      bus_ack = 1'b0;
      spi_value_valid = 1'b0;
      spi_cs_stop = 1'b0;
      r.touts += int'(timeout);
    end
    r.miso = spi_value_miso;
    r.late = 0;
    repeat (3) begin
      tick;
      r.late += int'(bus_req);
      r.touts += int'(timeout);
    end
  endtask
  task automatic cmp(input string tag, input res_t a, input res_t e);
    chk({tag, ".we"}, 32'(a.we), 32'(e.we));
    chk({tag, ".addr"}, 32'(a.addr), 32'(e.addr));
    chk({tag, ".wdata"}, 32'(a.wd), 32'(e.wd));
    chk({tag, ".busy"}, 32'(a.bsy), 32'(e.bsy));
    chk({tag, ".miso_busy"}, a.mbusy, e.mbusy);
    chk({tag, ".req_cycles"}, 32'(a.reqs), 32'(e.reqs));
    chk({tag, ".timeouts"}, 32'(a.touts), 32'(e.touts));
    chk({tag, ".overruns"}, 32'(a.ovr), 32'(e.ovr));
    chk({tag, ".miso_after"}, a.miso, e.miso);
    chk({tag, ".late_req"}, 32'(a.late), 32'(e.late));
  endtask
  initial begin
    vec_t tbl[7];
    res_t r;
    tbl[0] = '{32'h85123456, 3, 24'h777777, -1, 32'h0,
               '{1'b1, 7'h05, 24'h123456, 1'b1, 32'h85FFFFFF, 4, 0, 0, 32'h05123456, 0}};
    tbl[1] = '{32'h0A000000, 0, 24'hABCDEF, -1, 32'h0,
               '{1'b0, 7'h0A, 24'h000000, 1'b1, 32'h8AFFFFFF, 1, 0, 0, 32'h0AABCDEF, 0}};
    tbl[2] = '{32'h0A000000, 99, 24'h123123, -1, 32'h0,
               '{1'b0, 7'h0A, 24'h000000, 1'b1, 32'h8AFFFFFF, 16, 1, 0, 32'h8A000000, 0}};
    tbl[3] = '{32'h0A000000, 15, 24'h000001, -1, 32'h0,
               '{1'b0, 7'h0A, 24'h000000, 1'b1, 32'h8AFFFFFF, 16, 0, 0, 32'h0A000001, 0}};
    tbl[4] = '{32'hFF000000, 1, 24'h5A5A5A, -1, 32'h0,
               '{1'b1, 7'h7F, 24'h000000, 1'b1, 32'hFFFFFFFF, 2, 0, 0, 32'h7F000000, 0}};
    tbl[5] = '{32'h0A000000, 5, 24'h00C0DE, 2, 32'h85000001,
               '{1'b0, 7'h0A, 24'h000000, 1'b1, 32'h8AFFFFFF, 6, 0, 1, 32'h0A00C0DE, 0}};
    tbl[6] = '{32'h11000000, 0, 24'h00BEEF, 0, 32'h85000001,
               '{1'b0, 7'h11, 24'h000000, 1'b1, 32'h91FFFFFF, 1, 0, 1, 32'h1100BEEF, 0}};
    repeat (2) @(posedge system_clk);
    #1;
    chk("reset.miso", spi_value_miso, 32'h0);
    chk("reset.req", 32'(bus_req), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.timeout", 32'(timeout), 32'h0);
    chk("reset.overrun", 32'(overrun), 32'h0);
    chk("reset.addr", 32'(bus_addr), 32'h0);
    reset = 1'b0;
    tick;
    foreach (tbl[i]) begin
      run_cmd(tbl[i].cmd, tbl[i].delay, tbl[i].rdata, tbl[i].coll_at, tbl[i].coll, r);
      cmp($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    // Frame aborted before a full word: nothing starts, previous response is retained.
    spi_value_mosi = 32'h85000001;
    spi_cs_stop = 1'b1;
    spi_value_valid = 1'b0;
    #1;
    chk("short.overrun", 32'(overrun), 32'h0);
    tick;
    spi_cs_stop = 1'b0;
    chk("short.req", 32'(bus_req), 32'h0);
    chk("short.miso", spi_value_miso, 32'h1100BEEF);
    tick;
    chk("short.req2", 32'(bus_req), 32'h0);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] cmd, coll;
      logic [23:0] rd;
      int d, c;
      res_t e;
      cmd = $urandom;
      rd = 24'($urandom);
      coll = $urandom;
      d = $urandom_range(0, 20);
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1;
      e = model(cmd, d, rd, c);
      run_cmd(cmd, d, rd, c, coll, r);
      cmp($sformatf("rnd%0d", n), r, e);
    end
    // Reset in the middle of an access clears everything at once; a late ack must be ignored.
    spi_value_mosi = 32'h85ABCDEF;
    spi_value_valid = 1'b1;
    spi_cs_stop = 1'b1;
    tick;
    spi_value_valid = 1'b0;
    spi_cs_stop = 1'b0;
    chk("rst.req_before", 32'(bus_req), 32'h1);
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("rst.req", 32'(bus_req), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.miso", spi_value_miso, 32'h0);
    tick;
    reset = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 24'h123456;
    tick;
    bus_ack = 1'b0;
    chk("rst.late_ack_req", 32'(bus_req), 32'h0);
    chk("rst.late_ack_miso", spi_value_miso, 32'h0);
    chk("rst.late_ack_timeout", 32'(timeout), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
